// File: rtl/div_share_arb_if.sv
// div_share_arb_if: request and response bundle between the requesters, the arbiter and the result consumer
interface div_share_arb_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [8*NUM_REQ-1:0] req_lop;
    logic [8*NUM_REQ-1:0] req_rop;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [ID_W-1:0]      rsp_id;
    logic [7:0]           rsp_quot;
    logic [7:0]           rsp_mod;
    logic                 rsp_err;

    modport master (
        output req_valid, req_lop, req_rop, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_quot, rsp_mod, rsp_err
    );

    modport slave (
        input  req_valid, req_lop, req_rop, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_quot, rsp_mod, rsp_err
    );
endinterface

// File: rtl/div_share_arb.sv
// div_share_arb: round-robin sharing of one 8-bit restoring divider; DIV_SHARE_ZERO_CHECK_EN enables divide-by-zero flagging
module div_share_arb #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    div_share_arb_if.slave  bus,
    output logic            busy
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]    op_id_q, op_id_d;
    logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
    logic [7:0]         op_lop_q, op_lop_d;
    logic [7:0]         op_rop_q, op_rop_d;
    logic [7:0]         rsp_quot_q, rsp_quot_d;
    logic [7:0]         rsp_mod_q, rsp_mod_d;
    logic [7:0]         quot, mod;
    logic [8:0]         rem;
    logic [ID_W-1:0]    win_id;
    logic [NUM_REQ-1:0] gnt;
    logic               any_valid;
    int                 idx;

    // Round-robin search from rr_ptr upward; iterating offsets high to low leaves the nearest requester as winner
    always_comb begin
        win_id    = '0;
        any_valid = 1'b0;
        idx       = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (bus.req_valid[idx]) begin
                win_id    = ID_W'(idx);
                any_valid = 1'b1;
            end
        end
        gnt = '0;
        if (state_q == IDLE && any_valid && reset_n) gnt[win_id] = 1'b1;
    end

    // Restoring divider on the registered operands; a zero divisor naturally yields quot=FF, mod=lop
    always_comb begin
        rem  = '0;
        quot = '0;
        for (int i = 7; i >= 0; i--) begin
            rem = {rem[7:0], op_lop_q[i]};
            if (rem >= {1'b0, op_rop_q}) begin
                rem     = rem - {1'b0, op_rop_q};
                quot[i] = 1'b1;
            end
        end
        mod = rem[7:0];
    end

`ifdef DIV_SHARE_ZERO_CHECK_EN
    logic rsp_err_q, rsp_err_d;
    logic rop_zero;
    assign rop_zero = (op_rop_q == 8'h00);
`endif

    // Next-state logic: capture on grant, latch divider result in CALC, release and advance pointer on response accept
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        op_id_d    = op_id_q;
        op_lop_d   = op_lop_q;
        op_rop_d   = op_rop_q;
        rsp_id_d   = rsp_id_q;
        rsp_quot_d = rsp_quot_q;
        rsp_mod_d  = rsp_mod_q;
`ifdef DIV_SHARE_ZERO_CHECK_EN
        rsp_err_d  = rsp_err_q;
`endif
        if (state_q == IDLE && |gnt) begin
            state_d  = CALC;
            op_id_d  = win_id;
            op_lop_d = bus.req_lop[8*win_id +: 8];
            op_rop_d = bus.req_rop[8*win_id +: 8];
        end
        if (state_q == CALC) begin
            state_d    = RESP;
            rsp_id_d   = op_id_q;
`ifdef DIV_SHARE_ZERO_CHECK_EN
            rsp_quot_d = rop_zero ? 8'h00 : quot;
            rsp_mod_d  = rop_zero ? 8'h00 : mod;
            rsp_err_d  = rop_zero;
`else
            rsp_quot_d = quot;
            rsp_mod_d  = mod;
`endif
        end
        if (state_q == RESP && bus.rsp_ready) begin
            state_d  = IDLE;
            rr_ptr_d = (op_id_q == ID_W'(NUM_REQ - 1)) ? '0 : op_id_q + 1'b1;
        end
    end

    // State and datapath registers, all cleared by asynchronous reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            op_id_q    <= '0;
            op_lop_q   <= '0;
            op_rop_q   <= '0;
            rsp_id_q   <= '0;
            rsp_quot_q <= '0;
            rsp_mod_q  <= '0;
`ifdef DIV_SHARE_ZERO_CHECK_EN
            rsp_err_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            op_id_q    <= op_id_d;
            op_lop_q   <= op_lop_d;
            op_rop_q   <= op_rop_d;
            rsp_id_q   <= rsp_id_d;
            rsp_quot_q <= rsp_quot_d;
            rsp_mod_q  <= rsp_mod_d;
`ifdef DIV_SHARE_ZERO_CHECK_EN
            rsp_err_q  <= rsp_err_d;
`endif
        end
    end

    assign bus.req_ready = gnt;
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_quot  = rsp_quot_q;
    assign bus.rsp_mod   = rsp_mod_q;
`ifdef DIV_SHARE_ZERO_CHECK_EN
    assign bus.rsp_err   = rsp_err_q;
`else
    assign bus.rsp_err   = 1'b0;
`endif
    assign busy          = (state_q != IDLE);
endmodule

// File: tb/tb_div_share_arb.sv
// tb_div_share_arb: randomized and directed checks of div_share_arb against a transaction-level reference model
module tb_div_share_arb;
    localparam int NR = 4;

    logic clk = 1'b0;
    logic reset_n;
    logic busy;

    div_share_arb_if #(.NUM_REQ(NR), .ID_W(2)) bus ();

    div_share_arb #(.NUM_REQ(NR), .ID_W(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: pointer, age of the in-flight transaction (0 = none), its owner and expected result
    int          m_ptr = 0;
    int          m_age = 0;
    int          m_id  = 0;
    logic [16:0] m_res = '0;
    int          grants[$];
    int          gcyc[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // {err, quot, mod} as the arithmetic rules define them
    function automatic logic [16:0] exp_div(input logic [7:0] l, input logic [7:0] r);
        if (r == 8'd0) begin
`ifdef DIV_SHARE_ZERO_CHECK_EN
            return {1'b1, 8'h00, 8'h00};
`else
            return {1'b0, 8'hFF, l};
`endif
        end
        return {1'b0, 8'(l / r), 8'(l % r)};
    endfunction

    function automatic logic [31:0] rand_ops();
        logic [31:0] x;
        for (int b = 0; b < NR; b++) x[8*b +: 8] = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
        return x;
    endfunction

    // One clock: drive, check against the model, then advance the model across the rising edge
    task automatic step(input logic [NR-1:0] v, input logic [31:0] l, input logic [31:0] r, input logic rr);
        logic [NR-1:0] exp_rdy;
        int j;
        @(negedge clk);
        bus.req_valid = v;
        bus.req_lop   = l;
        bus.req_rop   = r;
        bus.rsp_ready = rr;
        #1;
        exp_rdy = '0;
        if (m_age == 0)
            for (int k = 0; k < NR; k++) begin
                j = (m_ptr + k) % NR;
                if (v[j] && exp_rdy == '0) exp_rdy[j] = 1'b1;
            end
        chk("req_ready", bus.req_ready, exp_rdy);
        chk("busy", busy, m_age != 0);
        chk("rsp_valid", bus.rsp_valid, m_age >= 2);
        if (m_age >= 2) begin
            chk("rsp_id", bus.rsp_id, m_id);
            chk("rsp_err", bus.rsp_err, m_res[16]);
            chk("rsp_quot", bus.rsp_quot, m_res[15:8]);
            chk("rsp_mod", bus.rsp_mod, m_res[7:0]);
        end
        @(posedge clk);
        cyc++;
        if (m_age == 0 && exp_rdy != '0) begin
            for (int k = 0; k < NR; k++) if (exp_rdy[k]) m_id = k;
            m_res = exp_div(l[8*m_id +: 8], r[8*m_id +: 8]);
            m_age = 1;
            grants.push_back(m_id);
            gcyc.push_back(cyc);
        end else if (m_age == 1) begin
            m_age = 2;
        end else if (m_age >= 2 && rr) begin
            m_ptr = (m_id + 1) % NR;
            m_age = 0;
        end
    endtask

    task automatic run_one(input int id, input logic [7:0] lop, input logic [7:0] rop);
        logic [31:0] l, r;
        l = rand_ops();
        r = rand_ops();
        l[8*id +: 8] = lop;
        r[8*id +: 8] = rop;
        step(NR'(1 << id), l, r, 1'b1);
        repeat (2) step('0, rand_ops(), rand_ops(), 1'b1);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
        chk({tag, "_rsp_id"}, bus.rsp_id, 0);
        chk({tag, "_rsp_quot"}, bus.rsp_quot, 0);
        chk({tag, "_rsp_mod"}, bus.rsp_mod, 0);
        chk({tag, "_rsp_err"}, bus.rsp_err, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_req_ready"}, bus.req_ready, 0);
    endtask

    task automatic reset_mid(input string tag);
        @(negedge clk);
        reset_n = 1'b0;
        bus.req_valid = '1;
        #1;
        check_reset_vals(tag);
        m_ptr = 0;
        m_age = 0;
        @(negedge clk);
        bus.req_valid = '0;
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n       = 1'b0;
        bus.req_valid = '1;
        bus.req_lop   = '0;
        bus.req_rop   = '0;
        bus.rsp_ready = 1'b0;
        #3;
        check_reset_vals("init");
        @(negedge clk);
        bus.req_valid = '0;
        reset_n = 1'b1;

        // All requesters valid, consumer always ready: strict rotation, one grant every 3 cycles
        grants.delete();
        gcyc.delete();
        repeat (15) step('1, rand_ops(), rand_ops(), 1'b1);
        chk("rot_count", grants.size() >= 5, 1);
        for (int i = 0; i < 5; i++) begin
            chk("rot_order", grants[i], i % NR);
            if (i > 0) chk("rot_gap", gcyc[i] - gcyc[i-1], 3);
        end

        // Single request and boundary operands
        run_one(1, 8'd200, 8'd7);
        run_one(2, 8'h5A, 8'h00);
        run_one(0, 8'd255, 8'd1);
        run_one(3, 8'd3, 8'd255);
        run_one(1, 8'd255, 8'd255);
        run_one(1, 8'd17, 8'd5);

        // Backpressure: response held for 5 cycles, then next grant moves past the owner
        grants.delete();
        step('1, rand_ops(), rand_ops(), 1'b0);
        step('1, rand_ops(), rand_ops(), 1'b0);
        repeat (5) step('1, rand_ops(), rand_ops(), 1'b0);
        step('1, rand_ops(), rand_ops(), 1'b1);
        step('1, rand_ops(), rand_ops(), 1'b1);
        chk("bp_count", grants.size(), 2);
        chk("bp_next", grants[1], (grants[0] + 1) % NR);

        // Reset during CALC, then during RESP; the model restarts the pointer at 0
        step(4'b1000, rand_ops(), rand_ops(), 1'b1);
        reset_mid("rst_calc");
        step(4'b1100, rand_ops(), rand_ops(), 1'b1);
        step('0, rand_ops(), rand_ops(), 1'b0);
        reset_mid("rst_resp");
        grants.delete();
        step(4'b0110, rand_ops(), rand_ops(), 1'b1);
        chk("rst_first_grant", grants.size() > 0 ? grants[0] : -1, 1);
        repeat (2) step('0, rand_ops(), rand_ops(), 1'b1);

        // Randomized traffic with intermittent backpressure and dropped requests
        repeat (400) step(NR'($urandom), rand_ops(), rand_ops(), $urandom_range(0, 3) != 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
